// File: rtl/key_entry_conditioner_if.sv
// Key-entry bundle: raw button/switch inputs and conditioned strobe/digit outputs.
interface key_entry_conditioner_if;
  logic [3:0] btn_raw;
  logic [3:0] sw_raw;
  logic [3:0] enable_pulse;
  logic [3:0] digit_out;
  logic       key_held;
  logic       multi_press;

  modport master (
    output btn_raw, sw_raw,
    input  enable_pulse, digit_out, key_held, multi_press
  );

  modport slave (
    input  btn_raw, sw_raw,
    output enable_pulse, digit_out, key_held, multi_press
  );
endinterface

// File: rtl/key_entry_conditioner.sv
// Key-entry front end: synchronises the four digit buttons and switch bank,
// debounces the buttons, and emits one single-cycle strobe per accepted press
// with the switch value captured alongside it.
module key_entry_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  key_entry_conditioner_if.slave  kb
);

  if ((DEBOUNCE_CYCLES < 2) || ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_params
    $error("key_entry_conditioner: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  logic [3:0]       r_btn_s1, r_btn_s2;
  logic [3:0]       r_sw_s1, r_sw_s2;
  logic [3:0]       r_db;
  logic [3:0]       w_db_next;
  logic [3:0]       w_rise;
  logic [CNT_W-1:0] r_cnt [4];

  state_t           r_state, w_state_next;
  logic [3:0]       r_pulse, w_pulse_next;
  logic [3:0]       r_digit, w_digit_next;
  logic             r_multi, w_multi_next;
  logic             r_held;

  // Two-flop synchronisers for buttons and switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= kb.btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= kb.sw_raw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounced level flips only when a disagreement has persisted to the terminal count
  always_comb begin
    w_db_next = r_db;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((r_btn_s2[i] != r_db[i]) && (r_cnt[i] == CNT_LAST)) begin
        w_db_next[i] = r_btn_s2[i];
      end
    end
  end

  assign w_rise = w_db_next & ~r_db;

  // Per-button stability counters; any agreement or acceptance restarts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_db <= w_db_next;
      for (int unsigned i = 0; i < 4; i++) begin
        if ((r_btn_s2[i] == r_db[i]) || (r_cnt[i] == CNT_LAST)) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Accept the lowest-index rise when idle; stay held until every button is released
  always_comb begin
    w_state_next = r_state;
    w_pulse_next = '0;
    w_multi_next = 1'b0;
    w_digit_next = r_digit;
    case (r_state)
      ST_IDLE: begin
        if (w_rise != '0) begin
          // x & -x isolates the lowest set bit; x & (x-1) is nonzero iff >1 bit set
          w_pulse_next = w_rise & (~w_rise + 4'd1);
          w_multi_next = ((w_rise & (w_rise - 4'd1)) != '0);
          w_digit_next = r_sw_s2;
          w_state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_db_next == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pulse <= '0;
      r_digit <= '0;
      r_multi <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pulse <= w_pulse_next;
      r_digit <= w_digit_next;
      r_multi <= w_multi_next;
      r_held  <= (w_state_next == ST_HELD);
    end
  end

  assign kb.enable_pulse = r_pulse;
  assign kb.digit_out    = r_digit;
  assign kb.key_held     = r_held;
  assign kb.multi_press  = r_multi;

endmodule

// File: tb/tb_key_entry_conditioner.sv
// Bench for key_entry_conditioner with a short debounce window.
module tb_key_entry_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_entry_conditioner_if bus();

  key_entry_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .kb  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a press is a button whose synchronised value disagrees with
  // its accepted level for D consecutive cycles; only the first press while idle
  // is reported, and the idle condition returns when all accepted levels are low.
  logic [3:0] m_pipe_btn [2];
  logic [3:0] m_pipe_sw  [2];
  logic [3:0] m_lvl, m_new, m_rises;
  int         m_run [4];
  bit         m_hold;
  logic [3:0] m_pulse, m_digit;
  bit         m_multi;

  always @(posedge clk) begin
    if (rst) begin
      m_pipe_btn[0] = '0; m_pipe_btn[1] = '0;
      m_pipe_sw[0]  = '0; m_pipe_sw[1]  = '0;
      m_lvl = '0; m_hold = 0; m_pulse = '0; m_digit = '0; m_multi = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      m_new = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (m_pipe_btn[1][i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_new[i] = m_pipe_btn[1][i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_rises = m_new & ~m_lvl;
      m_pulse = '0;
      m_multi = 0;
      if (!m_hold) begin
        if (m_rises != '0) begin
          for (int i = 3; i >= 0; i--) if (m_rises[i]) m_pulse = 4'(1 << i);
          m_multi = ($countones(m_rises) > 1);
          m_digit = m_pipe_sw[1];
          m_hold  = 1;
        end
      end else if (m_new == '0) begin
        m_hold = 0;
      end
      m_lvl = m_new;
      m_pipe_btn[1] = m_pipe_btn[0]; m_pipe_btn[0] = bus.btn_raw;
      m_pipe_sw[1]  = m_pipe_sw[0];  m_pipe_sw[0]  = bus.sw_raw;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model", {bus.enable_pulse, bus.digit_out, bus.key_held, bus.multi_press},
            {m_pulse, m_digit, m_hold, m_multi});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(output logic [3:0] p, output int lat);
    p = '0; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.enable_pulse != '0) begin
        p = bus.enable_pulse; lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!bus.key_held) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [3:0] sw;
    logic [3:0] exp_pulse;
    logic [3:0] exp_digit;
    logic       exp_multi;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [3:0] p;
    logic [3:0] seen;
    int lat;

    tbl[0] = '{4'b0001, 4'd5,  4'b0001, 4'd5,  1'b0};
    tbl[1] = '{4'b0110, 4'd9,  4'b0010, 4'd9,  1'b1};
    tbl[2] = '{4'b1000, 4'd15, 4'b1000, 4'd15, 1'b0};
    tbl[3] = '{4'b1100, 4'd0,  4'b0100, 4'd0,  1'b1};
    tbl[4] = '{4'b1111, 4'd7,  4'b0001, 4'd7,  1'b1};
    tbl[5] = '{4'b0100, 4'd10, 4'b0100, 4'd10, 1'b0};

    bus.btn_raw = '0;
    bus.sw_raw  = '0;
    tick(3);
    chk_en = 1'b1;
    check("reset_outputs", {bus.enable_pulse, bus.digit_out, bus.key_held, bus.multi_press}, 0);
    rst = 1'b0;
    tick(3);

    // Table: press, check strobe/capture/latency, hold, release, check release latency
    for (int t = 0; t < 6; t++) begin
      bus.sw_raw  = tbl[t].sw;
      bus.btn_raw = tbl[t].btn;
      wait_pulse(p, lat);
      check("tbl_pulse", p, tbl[t].exp_pulse);
      check("tbl_latency", lat, 6);
      check("tbl_digit", bus.digit_out, tbl[t].exp_digit);
      check("tbl_multi", bus.multi_press, tbl[t].exp_multi);
      check("tbl_held", bus.key_held, 1);
      @(negedge clk);
      check("tbl_pulse_width", bus.enable_pulse, 0);
      check("tbl_multi_width", bus.multi_press, 0);
      tick(6);
      bus.btn_raw = '0;
      wait_idle(lat);
      check("tbl_release_latency", lat, 6);
      tick(2);
    end

    // Bounce on button 1: 1,0,1,0 then steady high
    seen = '0;
    bus.sw_raw = 4'd2;
    for (int b = 0; b < 4; b++) begin
      bus.btn_raw = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      seen = seen | bus.enable_pulse;
    end
    bus.btn_raw = 4'b0010;
    wait_pulse(p, lat);
    check("bounce_early_pulse", seen, 0);
    check("bounce_pulse", p, 4'b0010);
    check("bounce_latency", lat, 6);
    bus.btn_raw = '0;
    wait_idle(lat);
    tick(2);

    // Hold button 0, press button 3 while holding: ignored; then re-press 3 alone
    bus.btn_raw = 4'b0001;
    wait_pulse(p, lat);
    check("hold_first_pulse", p, 4'b0001);
    tick(2);
    bus.btn_raw = 4'b1001;
    seen = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen = seen | bus.enable_pulse;
    end
    check("hold_second_ignored", seen, 0);
    check("hold_still_held", bus.key_held, 1);
    bus.btn_raw = '0;
    wait_idle(lat);
    check("hold_release_latency", lat, 6);
    tick(2);
    bus.btn_raw = 4'b1000;
    wait_pulse(p, lat);
    check("repress_pulse", p, 4'b1000);
    bus.btn_raw = '0;
    wait_idle(lat);
    tick(2);

    // Digit capture: switch changes during hold must not reach digit_out
    bus.sw_raw  = 4'd9;
    bus.btn_raw = 4'b0001;
    wait_pulse(p, lat);
    check("capture_digit9", bus.digit_out, 9);
    bus.sw_raw = 4'd3;
    tick(10);
    check("capture_held_digit", bus.digit_out, 9);
    bus.btn_raw = '0;
    wait_idle(lat);
    tick(4);
    check("capture_between_presses", bus.digit_out, 9);
    bus.btn_raw = 4'b0100;
    wait_pulse(p, lat);
    check("capture_digit3", bus.digit_out, 3);
    bus.btn_raw = '0;
    wait_idle(lat);
    tick(2);

    // Reset mid-debounce with the button still held
    bus.btn_raw = 4'b0001;
    tick(4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {bus.enable_pulse, bus.digit_out, bus.key_held, bus.multi_press}, 0);
    rst = 1'b0;
    wait_pulse(p, lat);
    check("midrst_pulse", p, 4'b0001);
    check("midrst_latency", lat, 6);
    bus.btn_raw = '0;
    wait_idle(lat);
    tick(2);

    // Random stimulus against the model, with slow and fast button activity
    for (int c = 0; c < 4000; c++) begin
      int rate;
      rate = ((c / 500) % 2 == 0) ? 14 : 3;
      if ($urandom_range(rate) == 0) bus.btn_raw = 4'($urandom);
      if ($urandom_range(2) == 0)    bus.sw_raw  = 4'($urandom);
      rst = ($urandom_range(399) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.btn_raw = '0;
    tick(12);
    check("final_idle", bus.key_held, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
